// File: rtl/ifu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ifu_pkg                                                   |
// | Purpose  : Shared widths, timeout constants and miss FSM state type  |
// |            for the IFU miss-sequencing controller.                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ifu_pkg;

  localparam int TAG_WIDTH      = 28;   // line tag width (address minus offset)
  localparam int LINE_WIDTH     = 128;  // instruction line width
  localparam int MISS_CNT_WIDTH = 16;   // saturating miss counter width
  localparam int TIMER_WIDTH    = 8;    // WAIT-cycle timer width
  localparam int TIMEOUT_CYCLES = 255;  // WAIT cycles before a re-issue
  localparam int MAX_RETRY      = 2;    // re-issues allowed before giving up

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } t_miss_state;

endpackage
`default_nettype wire

// File: rtl/ifu_miss_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ifu_miss_timer                                            |
// | Purpose  : WAIT-cycle timer and retry counter for the miss           |
// |            controller. Raises retryOut when a wait expires with      |
// |            re-issues left, giveUpOut when the retries are exhausted. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ifu_miss_timer #(
  parameter int TIMEOUT_CYCLES = ifu_pkg::TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = ifu_pkg::MAX_RETRY
) (
  input  logic Clock,
  input  logic Rst,
  input  logic missAccept,  // new miss accepted in IDLE
  input  logic reqFire,     // memory request handshake in REQ
  input  logic inWait,      // FSM is in WAIT
  input  logic rspMatch,    // matching response this cycle
  output logic retryOut,    // wait expired, re-issue the request
  output logic giveUpOut    // wait expired, no retries left
);
  import ifu_pkg::*;

  localparam int c_retryWidth = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  // The timer starts at 0 in the first WAIT cycle, so expiring on the
  // last count keeps the FSM in WAIT for exactly TIMEOUT_CYCLES cycles.
  localparam logic [TIMER_WIDTH-1:0]  c_timerLast = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [c_retryWidth-1:0] c_maxRetry  = c_retryWidth'(MAX_RETRY);

  logic [TIMER_WIDTH-1:0]  r_timer;
  logic [c_retryWidth-1:0] r_retry;
  logic                    w_expire;
  logic                    w_retriesLeft;

  // A matching response always wins over an expiry in the same cycle.
  assign w_expire      = inWait && !rspMatch && (r_timer == c_timerLast);
  assign w_retriesLeft = (r_retry < c_maxRetry);
  assign retryOut      = w_expire && w_retriesLeft;
  assign giveUpOut     = w_expire && !w_retriesLeft;

  // Count WAIT cycles per issue; count re-issues per accepted miss.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_timer <= '0;
      r_retry <= '0;
    end else begin
      if (reqFire) begin
        r_timer <= '0;
      end else if (inWait) begin
        r_timer <= r_timer + 1'b1;
      end
      if (missAccept) begin
        r_retry <= '0;
      end else if (retryOut) begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifu_miss_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ifu_miss_ctrl                                             |
// | Purpose  : Sequences one outstanding instruction-cache miss at a     |
// |            time: accept tag, issue to memory, wait for the matching  |
// |            line, pulse a one-cycle fill into the cache.              |
// | Options  : IFU_MISS_TIMEOUT_EN - enables WAIT timeout, re-issue and  |
// |            sticky errorOut (otherwise WAIT is unbounded).            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ifu_miss_ctrl #(
  parameter int TAG_WIDTH      = ifu_pkg::TAG_WIDTH,
  parameter int LINE_WIDTH     = ifu_pkg::LINE_WIDTH,
  parameter int TIMEOUT_CYCLES = ifu_pkg::TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = ifu_pkg::MAX_RETRY
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  cache_missTagIn,
  input  logic                  cache_missValidIn,
  output logic                  cache_missReadyOut,
  output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
  output logic                  mem_reqValidOut,
  input  logic                  mem_reqReadyIn,
  input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
  input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
  input  logic                  mem_rspValidIn,
  output logic [TAG_WIDTH-1:0]  cache_fillTagOut,
  output logic [LINE_WIDTH-1:0] cache_fillLineOut,
  output logic                  cache_fillValidOut,
  output logic                  busyOut,
  output logic [15:0]           missCountOut,
  output logic                  errorOut
);
  import ifu_pkg::*;

  // The 8-bit WAIT timer cannot represent longer timeouts.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || MAX_RETRY < 0) begin : g_paramCheck
    $error("ifu_miss_ctrl: TIMEOUT_CYCLES must be 1..255 and MAX_RETRY >= 0");
  end

  t_miss_state               r_state;
  logic [TAG_WIDTH-1:0]      r_pendTag;
  logic [TAG_WIDTH-1:0]      r_fillTag;
  logic [LINE_WIDTH-1:0]     r_fillLine;
  logic                      r_reqValid;
  logic                      r_fillValid;
  logic [MISS_CNT_WIDTH-1:0] r_missCount;

  logic w_accept;
  logic w_reqFire;
  logic w_rspMatch;
  logic w_inWait;
  logic w_retry;
  logic w_giveUp;

  assign w_accept   = (r_state == IDLE) && cache_missValidIn;
  assign w_reqFire  = (r_state == REQ) && mem_reqReadyIn;
  assign w_inWait   = (r_state == WAIT);
  // Responses are only looked at in WAIT; anything else is dropped.
  assign w_rspMatch = w_inWait && mem_rspValidIn && (mem_rspTagIn == r_pendTag);

`ifdef IFU_MISS_TIMEOUT_EN
  logic r_error;

  ifu_miss_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRY      (MAX_RETRY)
  ) u_timer (
    .Clock      (Clock),
    .Rst        (Rst),
    .missAccept (w_accept),
    .reqFire    (w_reqFire),
    .inWait     (w_inWait),
    .rspMatch   (w_rspMatch),
    .retryOut   (w_retry),
    .giveUpOut  (w_giveUp)
  );

  // Sticky error flag: once a miss is abandoned it stays set until reset.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_error <= 1'b0;
    end else if (w_giveUp) begin
      r_error <= 1'b1;
    end
  end

  assign errorOut = r_error;
`else
  assign w_retry  = 1'b0;
  assign w_giveUp = 1'b0;
  assign errorOut = 1'b0;
`endif

  // Miss FSM with registered request/fill outputs and saturating miss count.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_pendTag   <= '0;
      r_fillTag   <= '0;
      r_fillLine  <= '0;
      r_reqValid  <= 1'b0;
      r_fillValid <= 1'b0;
      r_missCount <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pendTag  <= cache_missTagIn;
            r_reqValid <= 1'b1;
            r_state    <= REQ;
            if (r_missCount != '1) begin
              r_missCount <= r_missCount + 1'b1;
            end
          end
        end
        REQ: begin
          if (w_reqFire) begin
            r_reqValid <= 1'b0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (w_rspMatch) begin
            r_fillTag   <= r_pendTag;
            r_fillLine  <= mem_rspInsLineIn;
            r_fillValid <= 1'b1;
            r_state     <= FILL;
          end else if (w_giveUp) begin
            r_state <= IDLE;
          end else if (w_retry) begin
            r_reqValid <= 1'b1;
            r_state    <= REQ;
          end
        end
        FILL: begin
          r_fillValid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cache_missReadyOut = (r_state == IDLE);
  assign busyOut            = (r_state != IDLE);
  assign mem_reqTagOut      = r_pendTag;
  assign mem_reqValidOut    = r_reqValid;
  assign cache_fillTagOut   = r_fillTag;
  assign cache_fillLineOut  = r_fillLine;
  assign cache_fillValidOut = r_fillValid;
  assign missCountOut       = r_missCount;

endmodule
`default_nettype wire

// File: tb/tb_ifu_miss_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ifu_miss_ctrl                                          |
// | Purpose  : Self-checking bench for ifu_miss_ctrl: directed scenarios |
// |            plus randomized misses against a transaction-level model. |
// |            Timeout scenario runs when IFU_MISS_TIMEOUT_EN is set.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ifu_miss_ctrl;

  localparam int TW      = 28;
  localparam int LW      = 128;
  localparam int TIMEOUT = 255;
  localparam int RETRIES = 2;

  logic          Clock = 1'b0;
  logic          Rst   = 1'b1;
  logic [TW-1:0] cache_missTagIn = '0;
  logic          cache_missValidIn = 1'b0;
  logic          cache_missReadyOut;
  logic [TW-1:0] mem_reqTagOut;
  logic          mem_reqValidOut;
  logic          mem_reqReadyIn = 1'b0;
  logic [TW-1:0] mem_rspTagIn = '0;
  logic [LW-1:0] mem_rspInsLineIn = '0;
  logic          mem_rspValidIn = 1'b0;
  logic [TW-1:0] cache_fillTagOut;
  logic [LW-1:0] cache_fillLineOut;
  logic          cache_fillValidOut;
  logic          busyOut;
  logic [15:0]   missCountOut;
  logic          errorOut;

  ifu_miss_ctrl dut (
    .Clock              (Clock),
    .Rst                (Rst),
    .cache_missTagIn    (cache_missTagIn),
    .cache_missValidIn  (cache_missValidIn),
    .cache_missReadyOut (cache_missReadyOut),
    .mem_reqTagOut      (mem_reqTagOut),
    .mem_reqValidOut    (mem_reqValidOut),
    .mem_reqReadyIn     (mem_reqReadyIn),
    .mem_rspTagIn       (mem_rspTagIn),
    .mem_rspInsLineIn   (mem_rspInsLineIn),
    .mem_rspValidIn     (mem_rspValidIn),
    .cache_fillTagOut   (cache_fillTagOut),
    .cache_fillLineOut  (cache_fillLineOut),
    .cache_fillValidOut (cache_fillValidOut),
    .busyOut            (busyOut),
    .missCountOut       (missCountOut),
    .errorOut           (errorOut)
  );

  always #5 Clock = ~Clock;

  int nChecks = 0;
  int nPass   = 0;

  // Transaction-level model state: accepted-miss count and sticky error.
  int   expCount = 0;
  logic expErr   = 1'b0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // One complete miss transaction. Optionally leaves the next miss pending
  // on the cache side so it is presented while this one is in flight.
  task automatic doMiss(input logic [TW-1:0] tag, input logic [LW-1:0] line,
                        input int rdyDly, input int rspDly, input bit strays,
                        input bit holdNext, input logic [TW-1:0] nextTag);
    cache_missValidIn = 1'b1;
    cache_missTagIn   = tag;
    chk("missReady_idle", LW'(cache_missReadyOut), LW'(1));
    tick;
    if (holdNext) cache_missTagIn = nextTag;
    else          cache_missValidIn = 1'b0;
    if (expCount < 65535) expCount++;
    chk("reqValid_rise", LW'(mem_reqValidOut), LW'(1));
    chk("reqTag", LW'(mem_reqTagOut), LW'(tag));
    chk("missCount", LW'(missCountOut), LW'(expCount));
    chk("missReady_req", LW'(cache_missReadyOut), LW'(0));
    chk("busy_req", LW'(busyOut), LW'(1));
    for (int i = 0; i < rdyDly; i++) begin
      tick;
      chk("reqValid_hold", LW'(mem_reqValidOut), LW'(1));
      chk("reqTag_hold", LW'(mem_reqTagOut), LW'(tag));
      chk("missReady_hold", LW'(cache_missReadyOut), LW'(0));
    end
    mem_reqReadyIn = 1'b1;
    tick;
    mem_reqReadyIn = 1'b0;
    chk("reqValid_drop", LW'(mem_reqValidOut), LW'(0));
    for (int i = 0; i < rspDly; i++) begin
      if (strays) begin
        mem_rspValidIn   = 1'b1;
        mem_rspTagIn     = tag ^ TW'($urandom_range(1, 255));
        mem_rspInsLineIn = {$urandom, $urandom, $urandom, $urandom};
      end
      tick;
      mem_rspValidIn = 1'b0;
      chk("noFill_wait", LW'(cache_fillValidOut), LW'(0));
      chk("busy_wait", LW'(busyOut), LW'(1));
    end
    mem_rspValidIn   = 1'b1;
    mem_rspTagIn     = tag;
    mem_rspInsLineIn = line;
    tick;
    mem_rspValidIn   = 1'b0;
    mem_rspInsLineIn = ~line;
    chk("fillValid", LW'(cache_fillValidOut), LW'(1));
    chk("fillTag", LW'(cache_fillTagOut), LW'(tag));
    chk("fillLine", cache_fillLineOut, line);
    chk("missReady_fill", LW'(cache_missReadyOut), LW'(0));
    chk("error", LW'(errorOut), LW'(expErr));
    tick;
    chk("fillValid_drop", LW'(cache_fillValidOut), LW'(0));
    chk("fillTag_keep", LW'(cache_fillTagOut), LW'(tag));
    chk("fillLine_keep", cache_fillLineOut, line);
    chk("busy_idle", LW'(busyOut), LW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] tagR;
    logic [LW-1:0] lineR;
    bit            bad;

    // Reset state while Rst is held.
    #3;
    chk("rst_busy", LW'(busyOut), LW'(0));
    chk("rst_missReady", LW'(cache_missReadyOut), LW'(1));
    chk("rst_reqValid", LW'(mem_reqValidOut), LW'(0));
    chk("rst_fillValid", LW'(cache_fillValidOut), LW'(0));
    chk("rst_count", LW'(missCountOut), LW'(0));
    chk("rst_error", LW'(errorOut), LW'(0));
    tick;
    tick;
    Rst = 1'b0;
    tick;

    // Basic miss, immediate ready, response a cycle into WAIT.
    doMiss(TW'(28'h100), {4{32'hDEADBEEF}}, 0, 1, 1'b0, 1'b0, '0);

    // Request backpressure with a second miss held by the cache.
    doMiss(TW'(28'h200), {$urandom, $urandom, $urandom, $urandom}, 5, 2, 1'b0, 1'b1, TW'(28'h300));
    doMiss(TW'(28'h300), {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0, 1'b0, '0);

    // Stray responses with wrong tags before the real one.
    doMiss(TW'(28'h100), {4{32'h0BADF00D}}, 0, 2, 1'b1, 1'b0, '0);

    // Reset in the middle of WAIT abandons the miss.
    cache_missValidIn = 1'b1;
    cache_missTagIn   = TW'(28'h100);
    tick;
    cache_missValidIn = 1'b0;
    mem_reqReadyIn    = 1'b1;
    tick;
    mem_reqReadyIn    = 1'b0;
    chk("pre_rst_busy", LW'(busyOut), LW'(1));
    Rst = 1'b1;
    #2;
    expCount = 0;
    chk("async_rst_busy", LW'(busyOut), LW'(0));
    chk("async_rst_missReady", LW'(cache_missReadyOut), LW'(1));
    chk("async_rst_count", LW'(missCountOut), LW'(0));
    chk("async_rst_reqTag", LW'(mem_reqTagOut), LW'(0));
    chk("async_rst_fillTag", LW'(cache_fillTagOut), LW'(0));
    chk("async_rst_fillLine", cache_fillLineOut, LW'(0));
    #18;
    Rst = 1'b0;
    mem_rspValidIn   = 1'b1;
    mem_rspTagIn     = TW'(28'h100);
    mem_rspInsLineIn = {4{32'h12345678}};
    tick;
    mem_rspValidIn = 1'b0;
    chk("late_rsp_noFill", LW'(cache_fillValidOut), LW'(0));
    chk("late_rsp_idle", LW'(busyOut), LW'(0));
    tick;
    chk("late_rsp_noFill2", LW'(cache_fillValidOut), LW'(0));

    // Back-to-back misses, each next miss already waiting at the cache.
    for (int i = 0; i < 4; i++) begin
      doMiss(TW'(i), {16{8'(i + 1)}}, 0, 0, 1'b0, (i < 3), TW'(i + 1));
    end
    chk("count_after_b2b", LW'(missCountOut), LW'(4));

    // Randomized misses.
    for (int n = 0; n < 10; n++) begin
      tagR  = TW'($urandom);
      lineR = {$urandom, $urandom, $urandom, $urandom};
      doMiss(tagR, lineR, $urandom_range(0, 3), $urandom_range(0, 4),
             1'($urandom_range(0, 1)), 1'b0, '0);
    end

`ifdef IFU_MISS_TIMEOUT_EN
    // No response: two re-issues after TIMEOUT WAIT cycles each, then error.
    cache_missValidIn = 1'b1;
    cache_missTagIn   = TW'(28'h5A5);
    tick;
    cache_missValidIn = 1'b0;
    expCount++;
    for (int r = 0; r <= RETRIES; r++) begin
      chk("to_reqValid", LW'(mem_reqValidOut), LW'(1));
      chk("to_reqTag", LW'(mem_reqTagOut), LW'(28'h5A5));
      mem_reqReadyIn = 1'b1;
      tick;
      mem_reqReadyIn = 1'b0;
      bad = 1'b0;
      for (int c = 1; c < TIMEOUT; c++) begin
        if (mem_reqValidOut !== 1'b0 || cache_fillValidOut !== 1'b0 || busyOut !== 1'b1) bad = 1'b1;
        tick;
      end
      chk("to_wait_quiet", LW'(bad), LW'(0));
      chk("to_wait_lastcycle_reqValid", LW'(mem_reqValidOut), LW'(0));
      tick;
      if (r < RETRIES) begin
        chk("to_reissue", LW'(mem_reqValidOut), LW'(1));
      end else begin
        expErr = 1'b1;
        chk("to_error", LW'(errorOut), LW'(1));
        chk("to_idle", LW'(busyOut), LW'(0));
        chk("to_noFill", LW'(cache_fillValidOut), LW'(0));
        chk("to_reqValid_off", LW'(mem_reqValidOut), LW'(0));
      end
    end
    doMiss(TW'(28'h777), {4{32'hCAFEF00D}}, 1, 1, 1'b0, 1'b0, '0);
    chk("to_error_sticky", LW'(errorOut), LW'(1));
`else
    chk("error_tied", LW'(errorOut), LW'(0));
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
